// File: rtl/bridge_pkg.sv
// ============================================================================
// Module   : bridge_pkg
// Brief    : Shared FSM encoding, register offsets and defaults for sys_bridge_n
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Word offsets inside the bridge register slot
  localparam logic [1:0]  IRQ_MASK_OFF   = 2'd0;
  localparam logic [1:0]  IRQ_RAW_OFF    = 2'd1;

  localparam logic [31:0] DEF_BASE       = 32'h0000_7F00;
  localparam int          DEF_SLOT_SHIFT = 4;

endpackage

`default_nettype wire

// File: rtl/bridge_addr_decode.sv
// ============================================================================
// Module   : bridge_addr_decode
// Brief    : Maps a CPU byte address onto a device slot, the bridge slot or unmapped
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter int          NDEV       = 2,
  parameter logic [31:0] BASE       = DEF_BASE,
  parameter int          SLOT_SHIFT = DEF_SLOT_SHIFT
) (
  input  logic [31:0] i_addr,
  output logic [2:0]  o_slot,
  output logic        o_hit_dev,
  output logic        o_hit_bridge,
  output logic        o_unmapped
);

  localparam logic [31:0] c_base_page = BASE >> SLOT_SHIFT;

  logic [31:0] w_page;
  logic [31:0] w_rel;

  // Addresses below BASE wrap to huge slot numbers and fall out as unmapped
  assign w_page       = i_addr >> SLOT_SHIFT;
  assign w_rel        = w_page - c_base_page;
  assign o_hit_dev    = (w_rel < 32'(NDEV));
  assign o_hit_bridge = (w_rel == 32'(NDEV));
  assign o_unmapped   = !(o_hit_dev || o_hit_bridge);
  assign o_slot       = w_rel[2:0];

endmodule

`default_nettype wire

// File: rtl/sys_bridge_n.sv
// ============================================================================
// Module   : sys_bridge_n
// Brief    : Registered CPU-to-device bridge with wait states, bus timeout and IRQ mask
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int          NDEV       = 2,
  parameter logic [31:0] BASE       = DEF_BASE,
  parameter int          SLOT_SHIFT = DEF_SLOT_SHIFT,
  parameter int          TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           PrAddr,
  input  logic [31:0]           PrWD,
  input  logic                  PrWE,
  input  logic                  PrReq,
  output logic                  PrReady,
  output logic [31:0]           PrRD,
  output logic                  PrErr,
  output logic [SLOT_SHIFT-3:0] Dev_Addr,
  output logic [31:0]           Dev_DataIn,
  output logic [NDEV-1:0]       Dev_Sel,
  output logic                  Dev_WE,
  input  logic [NDEV-1:0]       Dev_Ack,
  input  logic [32*NDEV-1:0]    Dev_RD,
  input  logic [NDEV-1:0]       Dev_IRQ,
  output logic [5:0]            HWInt
);

  localparam int         c_offw     = SLOT_SHIFT - 2;
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t              r_state, w_state_n;
  logic                r_ready, w_ready_n;
  logic                r_err, w_err_n;
  logic [31:0]         r_rd, w_rd_n;
  logic [NDEV-1:0]     r_sel, w_sel_n;
  logic                r_we, w_we_n;
  logic [c_offw-1:0]   r_addr, w_addr_n;
  logic [31:0]         r_wdata, w_wdata_n;
  logic [7:0]          r_cnt, w_cnt_n;
  logic [NDEV-1:0]     r_mask, w_mask_n;
  logic [5:0]          r_hwint;

  logic [2:0]          w_slot;
  logic                w_hit_dev, w_hit_bridge, w_unmapped;
  logic [NDEV-1:0]     w_onehot;
  logic [c_offw-1:0]   w_off;
  logic                w_ack;
  logic [31:0]         w_dev_rd;
  logic [31:0]         w_reg_rd;

  bridge_addr_decode #(
    .NDEV       (NDEV),
    .BASE       (BASE),
    .SLOT_SHIFT (SLOT_SHIFT)
  ) u_decode (
    .i_addr       (PrAddr),
    .o_slot       (w_slot),
    .o_hit_dev    (w_hit_dev),
    .o_hit_bridge (w_hit_bridge),
    .o_unmapped   (w_unmapped)
  );

  assign w_off = PrAddr[SLOT_SHIFT-1:2];
  assign w_ack = |(Dev_Ack & r_sel);

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NDEV; k++) w_onehot[k] = (w_slot == 3'(k));
  end

  // Read-data mux keyed by the held one-hot select
  always_comb begin
    w_dev_rd = '0;
    for (int k = 0; k < NDEV; k++)
      if (r_sel[k]) w_dev_rd = w_dev_rd | Dev_RD[32*k +: 32];
  end

  always_comb begin
    w_reg_rd = '0;
    if (w_off == c_offw'(IRQ_MASK_OFF))     w_reg_rd = 32'(r_mask);
    else if (w_off == c_offw'(IRQ_RAW_OFF)) w_reg_rd = 32'(Dev_IRQ);
  end

  always_comb begin
    w_state_n = r_state;
    w_ready_n = 1'b0;
    w_err_n   = r_err;
    w_rd_n    = r_rd;
    w_sel_n   = r_sel;
    w_we_n    = r_we;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_cnt_n   = r_cnt;
    w_mask_n  = r_mask;
    case (r_state)
      S_IDLE: begin
        if (PrReq) begin
          if (w_hit_dev) begin
            w_addr_n  = w_off;
            w_wdata_n = PrWD;
            w_we_n    = PrWE;
            w_sel_n   = w_onehot;
            w_cnt_n   = '0;
            w_state_n = S_ACCESS;
          end else if (w_hit_bridge) begin
            if (PrWE && (w_off == c_offw'(IRQ_MASK_OFF))) w_mask_n = PrWD[NDEV-1:0];
            w_rd_n    = PrWE ? '0 : w_reg_rd;
            w_err_n   = 1'b0;
            w_ready_n = 1'b1;
            w_state_n = S_RESP;
          end else if (w_unmapped) begin
            w_rd_n    = '0;
            w_err_n   = 1'b1;
            w_ready_n = 1'b1;
            w_state_n = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        // An ack on the final counted cycle still wins over the timeout
        if (w_ack) begin
          w_rd_n    = r_we ? '0 : w_dev_rd;
          w_err_n   = 1'b0;
          w_ready_n = 1'b1;
          w_sel_n   = '0;
          w_state_n = S_RESP;
        end else if (r_cnt == c_cnt_last) begin
          w_rd_n    = '0;
          w_err_n   = 1'b1;
          w_ready_n = 1'b1;
          w_sel_n   = '0;
          w_state_n = S_RESP;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_err_n   = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_mask  <= '1;
      r_hwint <= '0;
    end else begin
      r_state <= w_state_n;
      r_ready <= w_ready_n;
      r_err   <= w_err_n;
      r_rd    <= w_rd_n;
      r_sel   <= w_sel_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_cnt   <= w_cnt_n;
      r_mask  <= w_mask_n;
      r_hwint <= 6'(Dev_IRQ & r_mask);
    end
  end

  assign PrReady    = r_ready;
  assign PrErr      = r_err;
  assign PrRD       = r_rd;
  assign Dev_Sel    = r_sel;
  assign Dev_WE     = r_we;
  assign Dev_Addr   = r_addr;
  assign Dev_DataIn = r_wdata;
  assign HWInt      = r_hwint;

endmodule

`default_nettype wire
